puf_soc_tx_arbiter: RTL and testbench
=====================================

PUF_SOC_TX_ARBITER -- requirements
Module: puf_soc_tx_arbiter

Interface
REQ-001 SHALL have parameter FRAM_SIZE, default 160, frame width in bits.
REQ-002 SHALL have parameter GAP_CYC, default 4, idle cycles enforced between frames (range 1..15).
REQ-003 SHALL have parameter STALL_MAX, default 255, consecutive link-stall cycles before abort (range 1..255).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: i_norm_valid  in  1; i_norm_data  in  FRAM_SIZE; o_norm_ready  out  1 -- normal-frame requester.
REQ-006 SHALL have ports: i_dbg_valid  in  1; i_dbg_data  in  FRAM_SIZE; o_dbg_ready  out  1 -- debug-frame requester.
REQ-007 SHALL have port: i_link_ready  in  1  downstream link can take a serial bit.
REQ-008 SHALL have serializer ports: o_ser_valid  out  1  load strobe; o_ser_data  out  FRAM_SIZE; o_ser_mode  out  1  (1 = debug frame); o_ser_en  out  1  shift enable; o_ser_ready  out  1  shift-ready to serializer; i_ser_ready  in  1  serializer idle; i_ser_done  in  1  frame-end pulse.
REQ-009 SHALL have status ports: o_busy  out  1; o_grant  out  2  (bit0 = normal, bit1 = debug, one-hot or zero); o_abort  out  1  one-cycle stall-abort pulse.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, SHIFT, GAP.
REQ-011 IDLE: when (i_norm_valid | i_dbg_valid) & i_ser_ready, SHALL grant one requester and assert its ready combinationally in the same cycle; a transfer occurs on valid & ready; next state LOAD.
REQ-012 Both valid in the same cycle: SHALL grant debug (fixed priority) unless the round-robin feature is compiled in (REQ-024).
REQ-013 On transfer, SHALL capture the data into a FRAM_SIZE holding register and the mode (1 for debug) into a mode flag; o_grant SHALL hold the winner until return to IDLE.
REQ-014 LOAD: SHALL assert o_ser_valid for exactly one cycle, with o_ser_data = holding register and o_ser_mode = mode flag; next state SHIFT.
REQ-015 SHIFT: SHALL assert o_ser_en = 1 and o_ser_ready = i_link_ready combinationally; o_ser_mode SHALL stay stable.
REQ-016 SHIFT: i_ser_done = 1 SHALL move to GAP on the next cycle; i_ser_done is ignored in all other states.
REQ-017 SHIFT: an 8-bit stall counter SHALL increment on each cycle with i_link_ready = 0 and clear when i_link_ready = 1; reaching STALL_MAX SHALL pulse o_abort for one cycle and move to GAP.
REQ-018 GAP: all serializer outputs SHALL be 0; a 4-bit counter SHALL run GAP_CYC cycles, then return to IDLE; requester readies SHALL be 0.
REQ-019 o_busy SHALL be 1 in every state except IDLE; requester readies SHALL be 0 outside IDLE.
REQ-020 o_ser_data SHALL be 0 except in LOAD; no requester ready SHALL be asserted while i_ser_ready = 0.

Reset
REQ-021 rst = 1 at a clock edge SHALL force IDLE from any state, including mid-SHIFT, and clear the holding register, mode flag, stall and gap counters, and round-robin pointer.
REQ-022 During and after reset, all outputs SHALL be 0 until the next grant.

Configuration
REQ-023 The macro PUF_SOC_TX_ARB_RR_EN SHALL select the arbitration policy.
REQ-024 With PUF_SOC_TX_ARB_RR_EN defined, simultaneous requests SHALL alternate: the last-granted requester loses; after reset the pointer favours debug. Without the macro, debug SHALL always win and no pointer register exists.

Structure
REQ-025 The shared package puf_soc_pkg SHALL hold the FSM state typedef (IDLE, LOAD, SHIFT, GAP) and the grant bit-index constants.
REQ-026 Arbitration SHALL reside in one sub-module, puf_soc_arb2, combinational grant plus an optional pointer register; the FSM and counters stay in the top.

Verification
REQ-027 Normal frame 0xA5 (zero-extended), i_link_ready = 1: grant 01, o_ser_valid 1 cycle after transfer with mode 0; after i_ser_done, 4 GAP cycles, then IDLE.
REQ-028 Both valid on the same cycle, fixed priority: debug granted first (o_grant = 10, mode 1); normal granted after the GAP; o_norm_ready held 0 meanwhile.
REQ-029 RR build, both continuously valid for 4 frames: grant sequence 10, 01, 10, 01.
REQ-030 i_link_ready held 0 in SHIFT: o_abort pulses exactly at stall count 255, then GAP, then IDLE; serializer outputs 0 in GAP.
REQ-031 rst asserted mid-SHIFT: next cycle state IDLE, all outputs 0; a new request is accepted on the first cycle after reset deasserts.
REQ-032 i_ser_ready = 0 with i_norm_valid = 1: o_norm_ready stays 0 until i_ser_ready = 1, then grants on that cycle.

Source files
------------

// File: rtl/puf_soc_pkg.sv
// Shared types for the PUF SoC transmit arbiter: FSM states and grant bit positions.
package puf_soc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } tx_state_t;

  localparam int GNT_NORM = 0;
  localparam int GNT_DBG  = 1;

  localparam int STALL_W = 8;
  localparam int GAP_W   = 4;

endpackage

// File: rtl/puf_soc_arb2.sv
// Two-requester grant logic for the transmit arbiter.
// PUF_SOC_TX_ARB_RR_EN selects alternating priority; otherwise debug always wins.
module puf_soc_arb2
  import puf_soc_pkg::*;
(
`ifdef PUF_SOC_TX_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       update,
`endif
  input  logic       enable,
  input  logic       norm_valid,
  input  logic       dbg_valid,
  output logic [1:0] grant
);

  logic dbg_first;

`ifdef PUF_SOC_TX_ARB_RR_EN
  logic ptr_dbg_q;

  // The requester granted last loses the next tie; debug is favoured out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_dbg_q <= 1'b1;
    end else if (update) begin
      ptr_dbg_q <= grant[GNT_NORM];
    end
  end

  assign dbg_first = ptr_dbg_q;
`else
  assign dbg_first = 1'b1;
`endif

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (dbg_valid && (dbg_first || !norm_valid)) begin
        grant[GNT_DBG] = 1'b1;
      end else if (norm_valid) begin
        grant[GNT_NORM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/puf_soc_tx_arbiter.sv
// Arbitrates normal/debug frames onto a single serializer with link-stall abort and inter-frame gap.
// Build option PUF_SOC_TX_ARB_RR_EN enables round-robin tie breaking in puf_soc_arb2.
//
// state | meaning
// IDLE  | waiting for a request while the serializer is idle; grant is combinational
// LOAD  | one-cycle load strobe of the captured frame to the serializer
// SHIFT | serializer shifting; stall counter watches i_link_ready
// GAP   | enforced idle time of GAP_CYC cycles before the next grant
module puf_soc_tx_arbiter
  import puf_soc_pkg::*;
#(
  parameter int FRAM_SIZE = 160,
  parameter int GAP_CYC   = 4,
  parameter int STALL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_norm_valid,
  input  logic [FRAM_SIZE-1:0] i_norm_data,
  output logic                 o_norm_ready,
  input  logic                 i_dbg_valid,
  input  logic [FRAM_SIZE-1:0] i_dbg_data,
  output logic                 o_dbg_ready,
  input  logic                 i_link_ready,
  output logic                 o_ser_valid,
  output logic [FRAM_SIZE-1:0] o_ser_data,
  output logic                 o_ser_mode,
  output logic                 o_ser_en,
  output logic                 o_ser_ready,
  input  logic                 i_ser_ready,
  input  logic                 i_ser_done,
  output logic                 o_busy,
  output logic [1:0]           o_grant,
  output logic                 o_abort
);

  tx_state_t            state_q, state_d;
  logic [FRAM_SIZE-1:0] hold_q;
  logic                 mode_q;
  logic [1:0]           grant_q;
  logic [1:0]           arb_grant;
  logic [STALL_W-1:0]   stall_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 arb_en;
  logic                 xfer;

  assign arb_en = (state_q == IDLE) && !rst && i_ser_ready;
  assign xfer   = (arb_grant[GNT_NORM] && i_norm_valid) ||
                  (arb_grant[GNT_DBG]  && i_dbg_valid);

  puf_soc_arb2 u_arb (
`ifdef PUF_SOC_TX_ARB_RR_EN
    .clk        (clk),
    .rst        (rst),
    .update     (xfer),
`endif
    .enable     (arb_en),
    .norm_valid (i_norm_valid),
    .dbg_valid  (i_dbg_valid),
    .grant      (arb_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mode_q  <= 1'b0;
      grant_q <= 2'b00;
      stall_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        hold_q  <= arb_grant[GNT_DBG] ? i_dbg_data : i_norm_data;
        mode_q  <= arb_grant[GNT_DBG];
        grant_q <= arb_grant;
      end else if (state_q == GAP && state_d == IDLE) begin
        grant_q <= 2'b00;
      end
      stall_q <= (state_q == SHIFT && !i_link_ready) ? stall_q + 1'b1 : '0;
      gap_q   <= (state_q == GAP) ? gap_q + 1'b1 : '0;
    end
  end

  // Everything is forced low while rst is high, even before the first reset edge lands.
  always_comb begin
    state_d      = state_q;
    o_norm_ready = 1'b0;
    o_dbg_ready  = 1'b0;
    o_ser_valid  = 1'b0;
    o_ser_data   = '0;
    o_ser_mode   = 1'b0;
    o_ser_en     = 1'b0;
    o_ser_ready  = 1'b0;
    o_busy       = 1'b0;
    o_grant      = 2'b00;
    o_abort      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          o_norm_ready = arb_grant[GNT_NORM];
          o_dbg_ready  = arb_grant[GNT_DBG];
          o_grant      = arb_grant;
          if (xfer) state_d = LOAD;
        end
        LOAD: begin
          o_busy      = 1'b1;
          o_grant     = grant_q;
          o_ser_valid = 1'b1;
          o_ser_data  = hold_q;
          o_ser_mode  = mode_q;
          state_d     = SHIFT;
        end
        SHIFT: begin
          o_busy      = 1'b1;
          o_grant     = grant_q;
          o_ser_en    = 1'b1;
          o_ser_ready = i_link_ready;
          o_ser_mode  = mode_q;
          // A frame end in the same cycle as the final stall wins over the abort.
          if (i_ser_done) begin
            state_d = GAP;
          end else if (!i_link_ready && stall_q == STALL_W'(STALL_MAX - 1)) begin
            o_abort = 1'b1;
            state_d = GAP;
          end
        end
        GAP: begin
          o_busy  = 1'b1;
          o_grant = grant_q;
          if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_soc_tx_arbiter.sv
// Self-checking bench for puf_soc_tx_arbiter against a frame-level reference model.
module tb_puf_soc_tx_arbiter;

  localparam int FW        = 160;
  localparam int GAP_CYC   = 4;
  localparam int STALL_MAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_norm_valid = 1'b0;
  logic [FW-1:0] i_norm_data = '0;
  logic          o_norm_ready;
  logic          i_dbg_valid = 1'b0;
  logic [FW-1:0] i_dbg_data = '0;
  logic          o_dbg_ready;
  logic          i_link_ready = 1'b0;
  logic          o_ser_valid;
  logic [FW-1:0] o_ser_data;
  logic          o_ser_mode;
  logic          o_ser_en;
  logic          o_ser_ready;
  logic          i_ser_ready = 1'b0;
  logic          i_ser_done = 1'b0;
  logic          o_busy;
  logic [1:0]    o_grant;
  logic          o_abort;

  int checks   = 0;
  int failures = 0;

  // Model state: whether the most recent grant went to debug (tie breaker for round robin).
  bit last_dbg = 1'b0;
  bit shift_pat[$];

  logic [9:0] obs;
  assign obs = {o_busy, o_grant, o_norm_ready, o_dbg_ready,
                o_ser_valid, o_ser_mode, o_ser_en, o_ser_ready, o_abort};

  puf_soc_tx_arbiter #(.FRAM_SIZE(FW), .GAP_CYC(GAP_CYC), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_norm_valid(i_norm_valid), .i_norm_data(i_norm_data), .o_norm_ready(o_norm_ready),
    .i_dbg_valid(i_dbg_valid), .i_dbg_data(i_dbg_data), .o_dbg_ready(o_dbg_ready),
    .i_link_ready(i_link_ready),
    .o_ser_valid(o_ser_valid), .o_ser_data(o_ser_data), .o_ser_mode(o_ser_mode),
    .o_ser_en(o_ser_en), .o_ser_ready(o_ser_ready),
    .i_ser_ready(i_ser_ready), .i_ser_done(i_ser_done),
    .o_busy(o_busy), .o_grant(o_grant), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected winner from the arbitration rules: a lone requester wins; a tie goes to debug,
  // or with round robin to whichever side did not win last.
  function automatic logic [1:0] pick(bit nv, bit dv);
    if (nv && dv) begin
`ifdef PUF_SOC_TX_ARB_RR_EN
      return last_dbg ? 2'b01 : 2'b10;
`else
      return 2'b10;
`endif
    end
    if (dv) return 2'b10;
    if (nv) return 2'b01;
    return 2'b00;
  endfunction

  // Drives one frame from the grant cycle through LOAD, SHIFT (link pattern from shift_pat) and GAP.
  // stay_in_shift leaves the DUT in SHIFT after the pattern instead of finishing the frame.
  task automatic run_frame(input bit nv, input bit dv, input bit nv_after, input bit dv_after,
                           input logic [FW-1:0] nd, input logic [FW-1:0] dd,
                           input bit stay_in_shift, input string tag);
    logic [1:0]    w;
    logic [FW-1:0] exp_d;
    bit            m, lk, dn, ab;
    int            consec;
    w = pick(nv, dv);
    tick();
    rst = 1'b0; i_ser_ready = 1'b1; i_ser_done = 1'b0; i_link_ready = 1'b1;
    i_norm_valid = nv; i_dbg_valid = dv; i_norm_data = nd; i_dbg_data = dd;
    #1;
    checks++;
    if (obs !== {1'b0, w, w[0], w[1], 5'b0}) begin
      failures++;
      $display("FAIL %s grant got=%b exp=%b", tag, obs, {1'b0, w, w[0], w[1], 5'b0});
    end
    last_dbg = w[1];
    m        = w[1];
    exp_d    = m ? dd : nd;

    tick();
    i_norm_valid = nv_after; i_dbg_valid = dv_after;
    i_ser_done = 1'($urandom % 2); i_norm_data = rand_frame(); i_dbg_data = rand_frame();
    #1;
    checks++;
    if (obs !== {1'b1, w, 2'b00, 1'b1, m, 3'b000} || o_ser_data !== exp_d) begin
      failures++;
      $display("FAIL %s load got=%b data=%h exp=%b data=%h", tag, obs, o_ser_data,
               {1'b1, w, 2'b00, 1'b1, m, 3'b000}, exp_d);
    end

    consec = 0;
    ab     = 1'b0;
    for (int k = 0; k < shift_pat.size(); k++) begin
      tick();
      lk = shift_pat[k];
      dn = !stay_in_shift && (k == shift_pat.size() - 1);
      i_link_ready = lk; i_ser_done = dn;
      #1;
      consec = lk ? 0 : consec + 1;
      ab     = !dn && (consec == STALL_MAX);
      checks++;
      if (obs !== {1'b1, w, 2'b00, 1'b0, m, 1'b1, lk, ab} || o_ser_data !== '0) begin
        failures++;
        $display("FAIL %s shift[%0d] got=%b exp=%b data=%h", tag, k, obs,
                 {1'b1, w, 2'b00, 1'b0, m, 1'b1, lk, ab}, o_ser_data);
      end
      if (ab) break;
    end
    if (stay_in_shift && !ab) return;

    for (int g = 0; g < GAP_CYC; g++) begin
      tick();
      i_link_ready = 1'($urandom % 2); i_ser_done = 1'($urandom % 2);
      #1;
      checks++;
      if (obs !== {1'b1, w, 7'b0} || o_ser_data !== '0) begin
        failures++;
        $display("FAIL %s gap[%0d] got=%b exp=%b data=%h", tag, g, obs, {1'b1, w, 7'b0}, o_ser_data);
      end
    end
    i_ser_done = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    tick();
    i_norm_valid = 1'b0; i_dbg_valid = 1'b0; i_ser_done = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b0 || o_ser_data !== '0) begin
      failures++;
      $display("FAIL %s idle got=%b exp=%b data=%h", tag, obs, 10'b0, o_ser_data);
    end
  endtask

  task automatic make_pat(input int len);
    shift_pat.delete();
    for (int k = 0; k < len; k++) shift_pat.push_back(1'($urandom % 2));
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      rst = 1'b1; i_norm_valid = 1'b1; i_dbg_valid = 1'b1; i_ser_ready = 1'b1;
      i_ser_done = 1'b1; i_link_ready = 1'b1;
      i_norm_data = rand_frame(); i_dbg_data = rand_frame();
      #1;
      checks++;
      if (obs !== 10'b0 || o_ser_data !== '0) begin
        failures++;
        $display("FAIL reset[%0d] got=%b data=%h exp=0", c, obs, o_ser_data);
      end
    end
    last_dbg = 1'b0;
    tick();
    rst = 1'b0; i_norm_valid = 1'b0; i_dbg_valid = 1'b0; i_ser_done = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b0 || o_ser_data !== '0) begin
      failures++;
      $display("FAIL reset_release got=%b data=%h exp=0", obs, o_ser_data);
    end
  endtask

  task automatic test_normal_frame();
    logic [FW-1:0] d;
    d = FW'(8'hA5);
    shift_pat = '{1, 1, 1, 1, 1};
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, d, rand_frame(), 1'b0, "normal_a5");
    expect_idle("normal_a5");
  endtask

  task automatic test_random_frames();
    bit nv, dv;
    for (int f = 0; f < 10; f++) begin
      nv = 1'($urandom % 2);
      dv = 1'($urandom % 2);
      if (!nv && !dv) nv = 1'b1;
      make_pat(1 + int'($urandom % 8));
      run_frame(nv, dv, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b0, "random");
    end
    expect_idle("random");
  endtask

  task automatic test_both_valid();
    tick();
    rst = 1'b1;
    #1;
    last_dbg = 1'b0;
    make_pat(3);
    run_frame(1'b1, 1'b1, 1'b1, 1'b0, rand_frame(), rand_frame(), 1'b0, "both_first");
    make_pat(2);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b0, "both_second");
    expect_idle("both");
  endtask

  task automatic test_back_to_back();
    tick();
    rst = 1'b1;
    #1;
    last_dbg = 1'b0;
    for (int f = 0; f < 4; f++) begin
      make_pat(2 + int'($urandom % 4));
      run_frame(1'b1, 1'b1, 1'b1, 1'b1, rand_frame(), rand_frame(), 1'b0, "b2b");
    end
    expect_idle("b2b");
  endtask

  task automatic test_stall_abort();
    shift_pat.delete();
    for (int k = 0; k < STALL_MAX - 1; k++) shift_pat.push_back(1'b0);
    shift_pat.push_back(1'b1);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b0, "stall_edge");
    shift_pat.delete();
    for (int k = 0; k < 200; k++) shift_pat.push_back(1'b0);
    shift_pat.push_back(1'b1);
    for (int k = 0; k < STALL_MAX; k++) shift_pat.push_back(1'b0);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b1, "stall_abort");
    expect_idle("stall_abort");
  endtask

  task automatic test_reset_mid_shift();
    make_pat(4);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b1, "mid_shift");
    tick();
    rst = 1'b1; i_norm_valid = 1'b1; i_link_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0 || o_ser_data !== '0) begin
      failures++;
      $display("FAIL mid_shift_reset got=%b data=%h exp=0", obs, o_ser_data);
    end
    last_dbg = 1'b0;
    make_pat(3);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b0, "after_reset");
    expect_idle("after_reset");
  endtask

  task automatic test_ser_not_ready();
    for (int c = 0; c < 4; c++) begin
      tick();
      i_ser_ready = 1'b0; i_norm_valid = 1'b1; i_dbg_valid = 1'(c % 2);
      #1;
      checks++;
      if (obs !== 10'b0) begin
        failures++;
        $display("FAIL ser_not_ready[%0d] got=%b exp=%b", c, obs, 10'b0);
      end
    end
    make_pat(2);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, rand_frame(), rand_frame(), 1'b0, "ser_ready_rise");
    expect_idle("ser_ready_rise");
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_random_frames();
    test_both_valid();
    test_back_to_back();
    test_stall_abort();
    test_reset_mid_shift();
    test_ser_not_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
